bcd_display_scanner: RTL and testbench

- Downstream stage of the binary-to-BCD converter.
- Takes a packed K-digit BCD word, holds it in a display register, and drives a time-multiplexed common-segment 7-segment display, one digit per refresh slot.
- New values are double-buffered and committed only at frame boundaries, so the display never shows a partial update.

---
 rtl/bcd_display_scanner.sv | 114 +++++++++++
 tb/tb_bcd_display_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: double-buffered K-digit BCD value on a time-multiplexed 7-segment display.
// Defining BCD_SCAN_LZB_EN adds leading-zero blanking of the upper digits.
module bcd_display_scanner #(
  parameter int K   = 2,
  parameter int DIV = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [4*K-1:0] bcd_in,
  input  logic           load,
  input  logic           blank,
  output logic           ready,
  output logic           frame_done,
  output logic [K-1:0]   an,
  output logic [6:0]     seg
);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic [4*K-1:0]   disp_reg;
  logic [4*K-1:0]   pend_reg;
  logic [4*K-1:0]   new_val;
  logic             pend_flag;
  logic             tick;
  logic             idx_last;
  logic             boundary;
  logic             commit;
  logic             ready_nxt;
  logic [3:0]       cur_digit;
  logic [K-1:0]     an_nxt;
  logic [6:0]       seg_nxt;
`ifdef BCD_SCAN_LZB_EN
  logic             lz_run;
  logic             lz_hit;
`endif

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // The last slot's tick is the frame boundary; commits happen only there.
  always_comb begin
    tick      = (div_cnt == CNT_W'(DIV - 1));
    idx_last  = (idx == IDX_W'(K - 1));
    boundary  = tick && idx_last;
    commit    = boundary && (load || pend_flag);
    new_val   = load ? bcd_in : pend_reg;
    ready_nxt = boundary ? 1'b1 : !(pend_flag || load);
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < K; i++) begin
      if (idx == IDX_W'(i)) cur_digit = disp_reg[4*i +: 4];
    end
    an_nxt  = blank ? '0 : (K'(1) << idx);
    seg_nxt = decode(cur_digit);
`ifdef BCD_SCAN_LZB_EN
    // Walk down from the top digit; digit 0 is excluded so a zero value still shows "0".
    lz_run = 1'b1;
    lz_hit = 1'b0;
    for (int i = K - 1; i > 0; i--) begin
      lz_run = lz_run && (disp_reg[4*i +: 4] == 4'd0);
      if ((idx == IDX_W'(i)) && lz_run) lz_hit = 1'b1;
    end
    if (lz_hit) seg_nxt = 7'h7F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_flag  <= 1'b0;
      ready      <= 1'b1;
      frame_done <= 1'b0;
      an         <= '0;
      seg        <= 7'h7F;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx_last ? '0 : idx + 1'b1;
      if (boundary) begin
        if (commit) begin
          disp_reg  <= new_val;
          pend_flag <= 1'b0;
        end
      end else begin
        pend_reg  <= new_val;
        pend_flag <= pend_flag || load;
      end
      frame_done <= commit;
      ready      <= ready_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (K=2, DIV=4): directed scenarios with literal expectations plus
// random traffic, all outputs compared every cycle against a slot/frame arithmetic model.
module tb_bcd_display_scanner;
  localparam int K     = 2;
  localparam int DIV   = 4;
  localparam int FRAME = K * DIV;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] bcd_in = 8'h00;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  logic       ready;
  logic       frame_done;
  logic [1:0] an;
  logic [6:0] seg;

  int checks = 0;
  int failures = 0;

  bcd_display_scanner #(.K(K), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load), .blank(blank),
    .ready(ready), .frame_done(frame_done), .an(an), .seg(seg));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Model: m_n counts edges since reset release; slot and frame position follow by division.
  int         m_n = 0;
  int         pos;
  bit         bnd;
  logic [7:0] m_disp = 8'h00;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] nv;
  bit         m_flag = 1'b0;
  logic [1:0] e_an = 2'b00;
  logic [6:0] e_seg = 7'h7F;
  bit         e_ready = 1'b1;
  bit         e_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_disp = 8'h00; m_pend = 8'h00; m_flag = 1'b0;
      e_an = 2'b00; e_seg = 7'h7F; e_ready = 1'b1; e_fd = 1'b0;
    end else begin
      pos   = (m_n / DIV) % K;
      e_an  = blank ? 2'b00 : 2'(1 << pos);
      e_seg = SEG_TAB[m_disp[4*pos +: 4]];
`ifdef BCD_SCAN_LZB_EN
      if (pos > 0 && (m_disp >> (4*pos)) == 8'd0) e_seg = 7'h7F;
`endif
      bnd = ((m_n % FRAME) == FRAME - 1);
      nv  = load ? bcd_in : m_pend;
      if (bnd) begin
        e_fd = load || m_flag;
        if (e_fd) begin
          m_disp = nv;
          m_flag = 1'b0;
        end
      end else begin
        e_fd   = 1'b0;
        m_pend = nv;
        m_flag = m_flag || load;
      end
      e_ready = !m_flag;
      m_n++;
    end
  end

  always @(negedge clk) begin
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("ready", 32'(ready), 32'(e_ready));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  end

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_slot(input logic [1:0] tgt);
    int i = 0;
    while (an !== tgt && i < 4 * FRAME) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic wait_an(input logic [1:0] tgt, input string nm, input logic [6:0] req);
    wait_slot(tgt);
    if (an !== tgt) check({nm, "_slot_timeout"}, 32'(an), 32'(tgt));
    else check(nm, 32'(seg), 32'(req));
  endtask

  task automatic wait_fd(input string nm);
    int i = 0;
    while (frame_done !== 1'b1 && i < 4 * FRAME) begin
      @(negedge clk);
      i++;
    end
    check(nm, 32'(frame_done), 32'd1);
  endtask

  task automatic count_fd(input int n, input string nm, input int req);
    int fdc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fdc += int'(frame_done);
    end
    check(nm, 32'(fdc), 32'(req));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'h0);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_an", 32'(an), 32'h1);
    check("first_seg", 32'(seg), 32'h40);
    repeat (4) @(negedge clk);
    check("slot1_an", 32'(an), 32'h2);

    // Mid-frame load of 42
    do_load(8'h42);
    check("ready_drop", 32'(ready), 32'h0);
    check("unchanged_seg", 32'(seg), 32'h40);
    wait_fd("fd_42");
    check("ready_rise", 32'(ready), 32'h1);
    wait_an(2'b01, "d0_42", 7'h24);
    wait_an(2'b10, "d1_42", 7'h19);

    // Latest load in a frame wins, one commit
    wait_slot(2'b10);
    wait_slot(2'b01);
    do_load(8'h11);
    do_load(8'h35);
    count_fd(12, "fd_once", 1);
    wait_an(2'b01, "d0_35", 7'h12);
    wait_an(2'b10, "d1_35", 7'h30);

    // Load in the boundary cycle commits at once
    wait_slot(2'b10);
    wait_slot(2'b01);
    repeat (6) @(negedge clk);
    do_load(8'h60);
    check("bnd_fd", 32'(frame_done), 32'h1);
    check("bnd_ready", 32'(ready), 32'h1);
    wait_an(2'b01, "d0_60", 7'h40);
    wait_an(2'b10, "d1_60", 7'h02);

    // Invalid digit and blanking
    do_load(8'hA7);
    wait_fd("fd_a7");
    wait_an(2'b01, "d0_a7", 7'h78);
    wait_an(2'b10, "d1_a7", 7'h3F);
    blank = 1'b1;
    @(negedge clk);
    check("blank_an", 32'(an), 32'h0);
    repeat (5) @(negedge clk);
    check("blank_an_hold", 32'(an), 32'h0);
    blank = 1'b0;
    repeat (2) @(negedge clk);

    // Leading zeros
    do_load(8'h05);
    wait_fd("fd_05");
    wait_an(2'b01, "d0_05", 7'h12);
`ifdef BCD_SCAN_LZB_EN
    wait_an(2'b10, "d1_05", 7'h7F);
`else
    wait_an(2'b10, "d1_05", 7'h40);
`endif
    do_load(8'h00);
    wait_fd("fd_00");
    wait_an(2'b01, "d0_00", 7'h40);

    // Reset mid-frame discards the pending update
    do_load(8'h99);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'h0);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_ready", 32'(ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_fd(20, "no_fd_after_rst", 0);
    wait_an(2'b10, "d1_after_rst", 7'h40);
    wait_an(2'b01, "d0_after_rst", 7'h40);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load   = ($urandom_range(0, 5) == 0);
      bcd_in = ($urandom_range(0, 3) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    load  = 1'b0;
    blank = 1'b0;
    repeat (FRAME * 2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
